restoring_divider: RTL and testbench

- Sequential shift-subtract divider; it is the inverse-operation companion to the lab's 8-bit shift-add multiplier.
- It divides an 8-bit dividend by an 8-bit divisor using one restoring iteration per clock.
- It produces an 8-bit quotient and an 8-bit remainder.
- It sits behind the same synchronized push-button/switch front end, and its results drive the HexDriver displays.

---
 rtl/div_pkg.sv | 6 +
 rtl/div_trial_sub.sv | 11 +
 rtl/restoring_divider.sv | 128 ++++++++++++
 tb/tb_restoring_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: state encoding and widths shared by restoring_divider and its bench.
package div_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXUP, DONE} div_state_t;
   localparam int DIV_WIDTH = 8;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: WIDTH+1-bit trial subtraction; o_borrow is the difference MSB.
module div_trial_sub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   i_a,
   input  logic [WIDTH:0]   i_b,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow
);
   assign {o_borrow, o_diff} = i_a - i_b;
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring divider, one iteration per clock.
// SIGNED_DIV_EN selects two's-complement operands with an extra FIXUP cycle.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Clr,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             Div_By_Zero
);
   localparam int CW = $clog2(WIDTH);

   div_state_t       r_state;
   logic             r_start_q;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_r, r_q, r_d;
   logic [WIDTH-1:0] r_quot, r_rem;
   logic             r_dbz;
   logic [WIDTH-1:0] w_diff, w_r_nx, w_q_nx, w_dvd_mag, w_dvs_mag;
   logic             w_borrow, w_last;

`ifdef SIGNED_DIV_EN
   logic             r_neg_q, r_neg_r;
   assign w_dvd_mag = Dividend[WIDTH-1] ? ~Dividend + 1'b1 : Dividend;
   assign w_dvs_mag = Divisor[WIDTH-1] ? ~Divisor + 1'b1 : Divisor;
`else
   assign w_dvd_mag = Dividend;
   assign w_dvs_mag = Divisor;
`endif

   div_trial_sub #(.WIDTH(WIDTH)) u_sub (
      .i_a      ({r_r, r_q[WIDTH-1]}),
      .i_b      ({1'b0, r_d}),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // A borrow means the trial failed: restore by keeping the shifted remainder.
   assign w_r_nx = w_borrow ? {r_r[WIDTH-2:0], r_q[WIDTH-1]} : w_diff;
   assign w_q_nx = {r_q[WIDTH-2:0], ~w_borrow};
   assign w_last = r_cnt == CW'(WIDTH - 1);

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         r_state   <= IDLE;
         r_start_q <= 1'b0;
         r_cnt     <= '0;
         r_r       <= '0;
         r_q       <= '0;
         r_d       <= '0;
         r_quot    <= '0;
         r_rem     <= '0;
         r_dbz     <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
`endif
      end else begin
         r_start_q <= Start;
         case (r_state)
            IDLE: begin
               if (Start && !r_start_q) r_state <= LOAD;
               if (Clr) begin
                  r_quot <= '0;
                  r_rem  <= '0;
                  r_dbz  <= 1'b0;
               end
            end
            LOAD: begin
               r_d   <= w_dvs_mag;
               r_r   <= '0;
               r_q   <= w_dvd_mag;
               r_cnt <= '0;
`ifdef SIGNED_DIV_EN
               r_neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
               r_neg_r <= Dividend[WIDTH-1];
`endif
               if (Divisor == '0) begin
                  r_quot  <= '1;
                  r_rem   <= Dividend;
                  r_dbz   <= 1'b1;
                  r_state <= DONE;
               end else
                  r_state <= ITER;
            end
            ITER: begin
               r_r   <= w_r_nx;
               r_q   <= w_q_nx;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
`ifdef SIGNED_DIV_EN
                  r_state <= FIXUP;
`else
                  r_quot  <= w_q_nx;
                  r_rem   <= w_r_nx;
                  r_dbz   <= 1'b0;
                  r_state <= DONE;
`endif
               end
            end
`ifdef SIGNED_DIV_EN
            FIXUP: begin
               r_quot  <= r_neg_q ? ~r_q + 1'b1 : r_q;
               r_rem   <= r_neg_r ? ~r_r + 1'b1 : r_r;
               r_dbz   <= 1'b0;
               r_state <= DONE;
            end
`endif
            DONE: if (!Start) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end

   assign Quotient    = r_quot;
   assign Remainder   = r_rem;
   assign Div_By_Zero = r_dbz;
   assign Done        = r_state == DONE;
   assign Busy        = r_state == LOAD || r_state == ITER || r_state == FIXUP;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: random and directed checks of restoring_divider against
// a plain-arithmetic reference model (SIGNED_DIV_EN selects the signed model).
module tb_restoring_divider;
   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Start = 1'b0;
   logic       Clr = 1'b0;
   logic [7:0] Dividend = '0;
   logic [7:0] Divisor = '0;
   logic [7:0] Quotient, Remainder;
   logic       Busy, Done, Div_By_Zero;
   int         n_cmp = 0;
   int         n_err = 0;

`ifdef SIGNED_DIV_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 10;
`endif

   restoring_divider dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Start       (Start),
      .Clr         (Clr),
      .Dividend    (Dividend),
      .Divisor     (Divisor),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .Busy        (Busy),
      .Done        (Done),
      .Div_By_Zero (Div_By_Zero)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic z);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (b == 8'd0) begin
         q = 8'hFF;
         r = a;
         z = 1'b1;
      end else begin
`ifdef SIGNED_DIV_EN
         q = 8'(sa / sb);
         r = 8'(sa % sb);
`else
         q = a / b;
         r = a % b;
`endif
         z = 1'b0;
      end
   endtask

   // One Start pulse; counts edges (including the sampling edge) until Done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
      logic [7:0] eq, er;
      logic       ez;
      int         n, busy;
      model(a, b, eq, er, ez);
      @(negedge Clk);
      Dividend = a;
      Divisor  = b;
      Start    = 1'b1;
      n = 0;
      busy = 0;
      while (!Done && n < 40) begin
         @(posedge Clk);
         #1;
         n++;
         if (Busy) busy++;
         Start = 1'b0;
      end
      chk({tag, "_lat"}, n, b == 8'd0 ? 2 : LAT);
      chk({tag, "_busy"}, busy, b == 8'd0 ? 1 : LAT - 1);
      chk({tag, "_quot"}, int'(Quotient), int'(eq));
      chk({tag, "_rem"}, int'(Remainder), int'(er));
      chk({tag, "_dbz"}, int'(Div_By_Zero), int'(ez));
      repeat (2) @(posedge Clk);
   endtask

   initial begin
      int busy, first_done;
      logic [7:0] ra, rb;
      #2;
      chk("reset_outs", int'({Quotient, Remainder, Busy, Done, Div_By_Zero}), 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;

      run_op(8'd100, 8'd7, "d100_7");
      run_op(8'h2A, 8'd0, "dbz");

      // Start held for 30 cycles: one operation, then Done until release.
      @(negedge Clk);
      Dividend = 8'd255;
      Divisor  = 8'd1;
      Start    = 1'b1;
      busy = 0;
      first_done = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge Clk);
         #1;
         if (Busy) busy++;
         if (Done && first_done == 0) first_done = i;
      end
      chk("hold_busy", busy, LAT - 1);
      chk("hold_lat", first_done, LAT);
      chk("hold_done", int'(Done), 1);
      chk("hold_quot", int'(Quotient), 255);
      chk("hold_rem", int'(Remainder), 0);
      @(negedge Clk);
      Start = 1'b0;
      @(posedge Clk);
      #1;
      chk("hold_release", int'(Done), 0);
      busy = 0;
      repeat (5) begin
         @(posedge Clk);
         #1;
         busy += int'(Busy) + int'(Done);
      end
      chk("hold_no_retrigger", busy, 0);

      // Reset mid-iteration wipes everything immediately.
      run_op(8'd100, 8'd7, "pre_rst");
      @(negedge Clk);
      Dividend = 8'd200;
      Divisor  = 8'd13;
      Start    = 1'b1;
      repeat (6) @(posedge Clk);
      Start = 1'b0;
      #3;
      Reset_n = 1'b0;
      #1;
      chk("async_rst", int'({Quotient, Remainder, Busy, Done, Div_By_Zero}), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      run_op(8'd200, 8'd13, "d200_13");

      run_op(8'd5, 8'd9, "d5_9");
      @(negedge Clk);
      Clr = 1'b1;
      @(posedge Clk);
      #1;
      Clr = 1'b0;
      chk("clr", int'({Quotient, Remainder, Div_By_Zero}), 0);

`ifdef SIGNED_DIV_EN
      run_op(8'h9C, 8'd7, "s_m100_7");
      run_op(8'h80, 8'hFF, "s_m128_m1");
`endif

      for (int k = 0; k < 40; k++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         run_op(ra, rb, $sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
